icache_fill_ctrl: RTL and testbench

- Direct-mapped instruction cache with refill controller. Sits between the PC register and the backing instruction memory, directly upstream of IF_ID.
- On a hit, it returns the instruction combinationally in the same cycle as the PC.
- On a miss, it raises iMemError so the hazard unit stalls PC and IF_ID. It then refills the whole line over a valid/ready backing-memory handshake.

---
 rtl/icache_fill_ctrl.sv | 133 +++++++++++++
 tb/tb_icache_fill_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a whole-line refill controller over a valid/ready memory port.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_fill_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        iMemError,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int LW = 30 - OB;
    localparam int TB = LW - IB;
    localparam logic [31:0]   NOP       = {6'd63, 26'd0};
    localparam logic [OB-1:0] LAST_WORD = OB'(WORDS - 1);
    localparam logic [OB-1:0] CNT_ONE   = OB'(1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

    state_t state, state_nxt;

    logic [OB-1:0] pc_off;
    logic [IB-1:0] pc_idx;
    logic [TB-1:0] pc_tag;
    logic          unused_pc_bits;

    logic [LINES-1:0] valid;
    logic [TB-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    // Line being refilled: {tag, index} of the missed address, plus the next word to fetch.
    logic [LW-1:0] fill_line;
    logic [OB-1:0] fill_cnt;
    logic [IB-1:0] fill_idx;
    logic [TB-1:0] fill_tag;

    logic hit, miss, accept, last;

    assign pc_off         = PC[OB+1:2];
    assign pc_idx         = PC[OB+IB+1:OB+2];
    assign pc_tag         = PC[31:OB+IB+2];
    assign unused_pc_bits = ^PC[1:0];

    assign fill_idx = fill_line[IB-1:0];
    assign fill_tag = fill_line[LW-1:IB];
    assign mem_addr = {fill_line, fill_cnt, 2'b00};

    assign accept = mem_req && mem_ready;
    assign last   = accept && (fill_cnt == LAST_WORD);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hit         = 1'b0;
        miss        = 1'b0;
        Instruction = NOP;
        iMemError   = 1'b1;
        case (state)
            IDLE: begin
                hit  = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
                miss = !hit;
                if (hit) begin
                    Instruction = data_mem[pc_idx][pc_off];
                    iMemError   = 1'b0;
                end else begin
                    state_nxt = FILL;
                end
            end
            FILL:    if (last) state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: only this is cleared by reset; an interrupted line never becomes valid.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid     <= '0;
            mem_req   <= 1'b0;
            fill_line <= '0;
            fill_cnt  <= '0;
        end else begin
            if (miss) begin
                mem_req   <= 1'b1;
                fill_line <= PC[31:OB+2];
                fill_cnt  <= '0;
            end
            if (accept) begin
                fill_cnt <= fill_cnt + CNT_ONE;
                if (last) begin
                    mem_req         <= 1'b0;
                    valid[fill_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) data_mem[fill_idx][fill_cnt] <= mem_rdata;
        if (last)   tag_mem[fill_idx]            <= fill_tag;
    end

`ifdef ICACHE_STATS_EN
    // Misses are counted on the IDLE->FILL transition, not per stalled cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: a residency-based reference model checked every cycle
// plus directed scenarios with literal expectations. Define ICACHE_STATS_EN to also check the counters.
module tb_icache_fill_ctrl;

    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam logic [31:0] NOP = 32'hFC000000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] PC = 32'h0;
    logic [31:0] Instruction;
    logic        iMemError;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int lat = 1;
    bit idle_ready = 1'b0;
    int wcnt = 0;

    icache_fill_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .Clk(Clk), .Rst(Rst), .PC(PC), .Instruction(Instruction), .iMemError(iMemError),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Backing memory image.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11111111;
            32'h4:   return 32'h22222222;
            32'h8:   return 32'h33333333;
            32'hC:   return 32'h44444444;
            32'h100: return 32'hAAAAAAAA;
            default: return 32'hC0DE0000 | a;
        endcase
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    // Memory responder: ready after `lat` idle cycles of each request; optional noise while idle.
    always @(posedge Clk) begin
        #1;
        if (!mem_req) begin
            mem_ready = idle_ready;
            wcnt = 0;
        end else if (wcnt >= lat) begin
            mem_ready = 1'b1;
            wcnt = 0;
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: which line address each index holds, and the refill phase.
    int          m_phase = 0;  // 0 lookup, 1 refill, 2 settle cycle
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    logic [31:0] m_base = '0;
    int          m_idx = 0;
    int          m_cnt = 0;
    int unsigned m_hits = 0, m_misses = 0;
    int          c_idx;
    logic [31:0] c_base;
    bit          c_hit;

    always @(negedge Clk) begin
        if (Rst) begin
            m_phase = 0;
            m_cnt = 0;
            m_hits = 0;
            m_misses = 0;
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end
        c_idx  = int'((PC / (4 * WORDS)) % LINES);
        c_base = PC - (PC % (4 * WORDS));
        c_hit  = (m_phase == 0) && m_valid[c_idx] && (m_line[c_idx] == c_base);
        chk("model_imemerror", {31'b0, iMemError}, {31'b0, !c_hit});
        chk("model_instruction", Instruction, c_hit ? mem_word(PC - (PC % 4)) : NOP);
        chk("model_mem_req", {31'b0, mem_req}, {31'b0, m_phase == 1});
        if (m_phase == 1) chk("model_mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
`ifdef ICACHE_STATS_EN
        chk("model_hit_cnt", hit_cnt, m_hits);
        chk("model_miss_cnt", miss_cnt, m_misses);
`endif
        if (!Rst) begin
            case (m_phase)
                0: if (c_hit) m_hits++;
                   else begin
                       m_misses++;
                       m_phase = 1;
                       m_base = c_base;
                       m_idx = c_idx;
                       m_cnt = 0;
                   end
                1: if (mem_ready) begin
                       m_cnt++;
                       if (m_cnt == WORDS) begin
                           m_valid[m_idx] = 1'b1;
                           m_line[m_idx] = m_base;
                           m_phase = 2;
                       end
                   end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic wait_hit(input int budget, output int stalls);
        stalls = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (!iMemError) return;
            stalls++;
        end
        checks++;
        errors++;
        $display("FAIL wait_hit: no hit within %0d cycles", budget);
    endtask

    task automatic step(input logic [31:0] pc_v);
        @(posedge Clk);
        #1;
        PC = pc_v;
    endtask

    initial begin
        int st;
        int n;
        logic [31:0] aq[$];

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_imemerror", {31'b0, iMemError}, 32'd1);
        chk("reset_instruction", Instruction, NOP);
        chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'h0);

        // Test 1: cold miss at 0x0 with one wait cycle per word
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        fork
            begin
                for (int i = 0; i < 30 && aq.size() < WORDS; i++) begin
                    @(negedge Clk);
                    if (mem_req && mem_ready) aq.push_back(mem_addr);
                end
            end
            wait_hit(30, st);
        join
        chk("t1_instruction", Instruction, 32'h11111111);
        chk("t1_stall_cycles", st, 32'd10);
        chk("t1_words", aq.size(), WORDS);
        for (int i = 0; i < aq.size(); i++) chk("t1_addr_seq", aq[i], 32'(4 * i));

        // Test 2: sequential hits, with stray mem_ready that must be ignored
        idle_ready = 1'b1;
        step(32'h4);
        @(negedge Clk);
        chk("t2_hit4", Instruction, 32'h22222222);
        chk("t2_req4", {31'b0, mem_req}, 32'd0);
        step(32'h8);
        @(negedge Clk);
        chk("t2_hit8", Instruction, 32'h33333333);
        step(32'hC);
        @(negedge Clk);
        chk("t2_hitC", Instruction, 32'h44444444);
        chk("t2_err", {31'b0, iMemError}, 32'd0);

        // Test 3: conflict eviction of index 0, zero-wait memory
        lat = 0;
        idle_ready = 1'b0;
        step(32'h100);
`ifdef ICACHE_STATS_EN
        chk("t6_hit_cnt", hit_cnt, 32'd4);
        chk("t6_miss_cnt", miss_cnt, 32'd1);
`endif
        wait_hit(20, st);
        chk("t3_instruction", Instruction, 32'hAAAAAAAA);
        chk("t3_penalty", st, WORDS + 2);
        step(32'h0);
        @(negedge Clk);
        chk("t3_evicted_miss", {31'b0, iMemError}, 32'd1);
        @(negedge Clk);
        chk("t3_refetch_req", {31'b0, mem_req}, 32'd1);
        chk("t3_refetch_addr", mem_addr, 32'h0);
        wait_hit(20, st);
        chk("t3_refetched", Instruction, 32'h11111111);

        // Test 4: reset after two of four words accepted
        step(32'h80);
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge Clk);
            if (mem_req && mem_ready) n++;
        end
        chk("t4_two_accepted", n, 32'd2);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        chk("t4_rst_req", {31'b0, mem_req}, 32'd0);
        chk("t4_rst_addr", mem_addr, 32'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        PC = 32'h0;
        @(negedge Clk);
        chk("t4_miss_after_rst", {31'b0, iMemError}, 32'd1);
        @(negedge Clk);
        chk("t4_refetch_req", {31'b0, mem_req}, 32'd1);
        chk("t4_refetch_addr", mem_addr, 32'h0);
        wait_hit(20, st);
        chk("t4_instruction", Instruction, 32'h11111111);
        step(32'h80);
        @(negedge Clk);
        chk("t4_partial_invalid", {31'b0, iMemError}, 32'd1);
        wait_hit(20, st);
        chk("t4_line80", Instruction, 32'hC0DE0080);

        // Test 5: PC moves during a fill
        lat = 1;
        step(32'h20);
        @(negedge Clk);
        chk("t5_miss", {31'b0, iMemError}, 32'd1);
        step(32'h40);
        aq.delete();
        for (int i = 0; i < 30 && aq.size() < WORDS; i++) begin
            @(negedge Clk);
            if (mem_req && mem_ready) aq.push_back(mem_addr);
        end
        chk("t5_words", aq.size(), WORDS);
        for (int i = 0; i < aq.size(); i++) chk("t5_addr_seq", aq[i], 32'h20 + 32'(4 * i));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (mem_req) begin
                n = 1;
                break;
            end
        end
        chk("t5_new_req", n, 32'd1);
        chk("t5_new_addr", mem_addr, 32'h40);
        wait_hit(30, st);
        chk("t5_instruction40", Instruction, 32'hC0DE0040);
        step(32'h20);
        @(negedge Clk);
        chk("t5_hit20_err", {31'b0, iMemError}, 32'd0);
        chk("t5_hit20", Instruction, 32'hC0DE0020);

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
